// File: rtl/clock_divider_ctrl_pkg.sv
// Shared types and constants for the run-time reconfigurable clock divider.
// Holds the controller state encoding and the divisor validity rule.
package clock_divider_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } t_div_state;

    localparam int c_div_min = 2;

    // A full-period divisor is usable only if it is even and at least c_div_min.
    function automatic logic div_is_valid(input logic [31:0] val);
        return (val >= 32'(c_div_min)) && (val[0] == 1'b0);
    endfunction

endpackage

// File: rtl/clock_divider_ctrl_if.sv
// Divisor-change handshake and divided-clock outputs of the clock divider.
// The requester drives the i_* side, the divider drives the o_* side.
interface clock_divider_ctrl_if #(
    parameter int par_div_width = 16
);
    logic                     i_div_req;
    logic [par_div_width-1:0] i_div_val;
    logic                     o_div_busy;
    logic                     o_div_ack;
    logic                     o_div_err;
    logic                     o_clk_div;
    logic                     o_rst_div;
    logic                     o_ce_rise;
    logic                     o_ce_fall;

    modport master (
        output i_div_req,
        output i_div_val,
        input  o_div_busy,
        input  o_div_ack,
        input  o_div_err,
        input  o_clk_div,
        input  o_rst_div,
        input  o_ce_rise,
        input  o_ce_fall
    );

    modport slave (
        input  i_div_req,
        input  i_div_val,
        output o_div_busy,
        output o_div_ack,
        output o_div_err,
        output o_clk_div,
        output o_rst_div,
        output o_ce_rise,
        output o_ce_fall
    );

endinterface

// File: rtl/clock_divider_ctrl_half_counter.sv
// Half-period counter holding the active half-period length.
// Counts 0..half-1; tc flags the last source cycle of the current level.
module div_half_counter #(
    parameter int par_cnt_width    = 15,
    parameter int par_half_default = 500
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     restart,
    input  logic                     load,
    input  logic [par_cnt_width-1:0] half_new,
    output logic                     tc
);

    localparam logic [par_cnt_width-1:0] c_half_default = par_cnt_width'(par_half_default);
    localparam logic [par_cnt_width-1:0] c_one          = par_cnt_width'(1);

    logic [par_cnt_width-1:0] count_reg;
    logic [par_cnt_width-1:0] half_reg;
    logic [par_cnt_width-1:0] count_next;

    always_comb begin
        count_next = count_reg + c_one;
        if (load || restart) begin
            count_next = '0;
        end
    end

    // Loading a new half-period also restarts the count so the new level
    // begins with a full-length phase.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
            half_reg  <= c_half_default;
        end else begin
            count_reg <= count_next;
            if (load) begin
                half_reg <= half_new;
            end
        end
    end

    assign tc = (count_reg == (half_reg - c_one));

endmodule

// File: rtl/clock_divider_ctrl.sv
// Even-ratio clock divider with glitch-free run-time divisor changes.
// Changes are applied only at a falling edge of the divided clock.
module clock_divider_ctrl
    import clock_divider_ctrl_pkg::*;
#(
    parameter int par_div_width     = 16,
    parameter int par_div_default   = 1000,
    parameter int par_rst_on_change = 1
) (
    input  logic                 i_clk_mhz,
    input  logic                 i_rst_mhz,
    clock_divider_ctrl_if.slave  bus
);

    localparam int   c_cnt_width     = par_div_width - 1;
    localparam logic c_rst_on_change = (par_rst_on_change != 0);

    t_div_state               state_reg;
    logic                     clk_div_reg;
    logic                     rst_div_reg;
    logic                     busy_reg;
    logic                     ack_reg;
    logic                     err_reg;
    logic                     ce_rise_reg;
    logic                     ce_fall_reg;
    logic [c_cnt_width-1:0]   pending_reg;

    logic                     tc;
    logic                     cnt_restart;
    logic                     change_edge;
    logic                     req_valid;

    assign req_valid   = div_is_valid(32'(bus.i_div_val));
    assign change_edge = (state_reg == ST_DRAIN) && tc && clk_div_reg;
    assign cnt_restart = (state_reg == ST_HOLD) || tc;

    div_half_counter #(
        .par_cnt_width    (c_cnt_width),
        .par_half_default (par_div_default / 2)
    ) u_half_counter (
        .clk      (i_clk_mhz),
        .srst     (i_rst_mhz),
        .restart  (cnt_restart),
        .load     (change_edge),
        .half_new (pending_reg),
        .tc       (tc)
    );

    always_ff @(posedge i_clk_mhz) begin
        if (i_rst_mhz) begin
            state_reg   <= ST_HOLD;
            clk_div_reg <= 1'b0;
            rst_div_reg <= 1'b1;
            busy_reg    <= 1'b0;
            ack_reg     <= 1'b0;
            err_reg     <= 1'b0;
            ce_rise_reg <= 1'b0;
            ce_fall_reg <= 1'b0;
            pending_reg <= '0;
        end else begin
            ack_reg     <= 1'b0;
            err_reg     <= 1'b0;
            ce_rise_reg <= 1'b0;
            ce_fall_reg <= 1'b0;
            case (state_reg)
                ST_HOLD: begin
                    state_reg   <= ST_RUN;
                    clk_div_reg <= 1'b1;
                    ce_rise_reg <= 1'b1;
                end
                ST_RUN: begin
                    if (tc) begin
                        clk_div_reg <= ~clk_div_reg;
                        ce_rise_reg <= ~clk_div_reg;
                        ce_fall_reg <= clk_div_reg;
                        if (clk_div_reg) begin
                            rst_div_reg <= 1'b0;
                        end
                    end
                    if (bus.i_div_req) begin
                        if (req_valid) begin
                            pending_reg <= bus.i_div_val[par_div_width-1:1];
                            busy_reg    <= 1'b1;
                            state_reg   <= ST_DRAIN;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Requests are ignored here; the old rate keeps running
                    // until the next high-to-low transition.
                    if (tc) begin
                        clk_div_reg <= ~clk_div_reg;
                        ce_rise_reg <= ~clk_div_reg;
                        ce_fall_reg <= clk_div_reg;
                    end
                    if (change_edge) begin
                        rst_div_reg <= c_rst_on_change;
                        ack_reg     <= 1'b1;
                        busy_reg    <= 1'b0;
                        state_reg   <= ST_RUN;
                    end
                end
                default: begin
                    state_reg <= ST_HOLD;
                end
            endcase
        end
    end

    assign bus.o_div_busy = busy_reg;
    assign bus.o_div_ack  = ack_reg;
    assign bus.o_div_err  = err_reg;
    assign bus.o_clk_div  = clk_div_reg;
    assign bus.o_rst_div  = rst_div_reg;
    assign bus.o_ce_rise  = ce_rise_reg;
    assign bus.o_ce_fall  = ce_fall_reg;

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Bench for clock_divider_ctrl: two instances (re-pulsed and plain divided reset)
// checked every cycle against a phase-length model plus literal expectations.
module tb_clock_divider_ctrl;

    localparam int div_width   = 16;
    localparam int div_default = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    clock_divider_ctrl_if #(.par_div_width(div_width)) if0 ();
    clock_divider_ctrl_if #(.par_div_width(div_width)) if1 ();

    assign if1.i_div_req = if0.i_div_req;
    assign if1.i_div_val = if0.i_div_val;

    clock_divider_ctrl #(
        .par_div_width     (div_width),
        .par_div_default   (div_default),
        .par_rst_on_change (1)
    ) dut0 (
        .i_clk_mhz (clk),
        .i_rst_mhz (rst),
        .bus       (if0)
    );

    clock_divider_ctrl #(
        .par_div_width     (div_width),
        .par_div_default   (div_default),
        .par_rst_on_change (0)
    ) dut1 (
        .i_clk_mhz (clk),
        .i_rst_mhz (rst),
        .bus       (if1)
    );

    int checks   = 0;
    int failures = 0;
    int ncyc     = 0;
    int ack_cnt  = 0;

    // Model: remaining cycles of the current level, active/pending half period.
    bit   m_run;
    bit   m_pend_v;
    int   m_left;
    int   m_half;
    int   m_pend;
    logic e_clk, e_rst1, e_rst0, e_busy, e_ack, e_err, e_rise, e_fall;

    bit   track_en = 1'b0;
    bit   trk_started;
    bit   trk_prev;
    bit   rst1_seen;
    int   trk_run;
    int   min_high;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, ncyc, act, exp);
        end
    endtask

    task automatic model_step();
        bit was_busy;
        int v;
        if (rst) begin
            m_run = 0; m_pend_v = 0; m_half = div_default / 2; m_left = 0;
            e_clk = 0; e_rst1 = 1; e_rst0 = 1; e_busy = 0;
            e_ack = 0; e_err = 0; e_rise = 0; e_fall = 0;
        end else if (!m_run) begin
            m_run = 1; m_left = m_half;
            e_clk = 1; e_rise = 1; e_fall = 0; e_ack = 0; e_err = 0;
        end else begin
            e_ack = 0; e_err = 0; e_rise = 0; e_fall = 0;
            was_busy = e_busy;
            m_left--;
            if (m_left == 0) begin
                if (e_clk) begin
                    e_clk = 0; e_fall = 1; e_rst0 = 0;
                    if (m_pend_v) begin
                        m_half = m_pend; m_pend_v = 0;
                        e_busy = 0; e_ack = 1; e_rst1 = 1;
                    end else begin
                        e_rst1 = 0;
                    end
                end else begin
                    e_clk = 1; e_rise = 1;
                end
                m_left = m_half;
            end
            if (!was_busy && if0.i_div_req) begin
                v = int'(if0.i_div_val);
                if (v >= 2 && (v % 2) == 0) begin
                    m_pend = v / 2; m_pend_v = 1; e_busy = 1;
                end else begin
                    e_err = 1;
                end
            end
        end
    endtask

    // Advance one source cycle, update the model, compare both instances.
    task automatic tick();
        @(negedge clk);
        ncyc++;
        model_step();
        chk("clk_div0",  if0.o_clk_div,  e_clk);
        chk("rst_div0",  if0.o_rst_div,  e_rst1);
        chk("busy0",     if0.o_div_busy, e_busy);
        chk("ack0",      if0.o_div_ack,  e_ack);
        chk("err0",      if0.o_div_err,  e_err);
        chk("ce_rise0",  if0.o_ce_rise,  e_rise);
        chk("ce_fall0",  if0.o_ce_fall,  e_fall);
        chk("clk_div1",  if1.o_clk_div,  e_clk);
        chk("rst_div1",  if1.o_rst_div,  e_rst0);
        chk("busy1",     if1.o_div_busy, e_busy);
        chk("ack1",      if1.o_div_ack,  e_ack);
        chk("err1",      if1.o_div_err,  e_err);
        chk("ce_rise1",  if1.o_ce_rise,  e_rise);
        chk("ce_fall1",  if1.o_ce_fall,  e_fall);
        if (if0.o_div_ack === 1'b1) ack_cnt++;
        if (!track_en) begin
            trk_started = 0; trk_run = 0; min_high = 1000; rst1_seen = 0;
            trk_prev = if1.o_clk_div;
        end else begin
            if (if1.o_rst_div === 1'b1) rst1_seen = 1;
            if (if1.o_clk_div === trk_prev) begin
                trk_run++;
            end else begin
                if (trk_started && trk_prev && trk_run < min_high) min_high = trk_run;
                trk_started = 1;
                trk_run = 1;
            end
            trk_prev = if1.o_clk_div;
        end
    endtask

    task automatic measure_high(output int len);
        bit found = 0;
        len = 0;
        for (int i = 0; i < 100; i++) begin
            if (if0.o_ce_rise === 1'b1) begin found = 1; break; end
            tick();
        end
        chk("rise_seen", 32'(found), 32'd1);
        if (found) begin
            len = 1;
            tick();
            while (if0.o_clk_div === 1'b1 && len < 100) begin
                len++;
                tick();
            end
        end
    endtask

    int len;
    int a0;
    bit found;

    initial begin
        rst = 1'b1;
        if0.i_div_req = 1'b0;
        if0.i_div_val = '0;
        repeat (3) tick();
        chk("lit_rst_clk",   32'(if0.o_clk_div),  32'd0);
        chk("lit_rst_rdiv",  32'(if0.o_rst_div),  32'd1);
        chk("lit_rst_busy",  32'(if0.o_div_busy), 32'd0);

        // Release: high at r+1, falling edge with reset drop at r+5.
        rst = 1'b0;
        tick();
        chk("lit_rel_clk",   32'(if0.o_clk_div),  32'd1);
        chk("lit_rel_rise",  32'(if0.o_ce_rise),  32'd1);
        chk("lit_rel_rdiv",  32'(if0.o_rst_div),  32'd1);
        repeat (3) tick();
        chk("lit_r4_clk",    32'(if0.o_clk_div),  32'd1);
        tick();
        chk("lit_r5_clk",    32'(if0.o_clk_div),  32'd0);
        chk("lit_r5_fall",   32'(if0.o_ce_fall),  32'd1);
        chk("lit_r5_rdiv",   32'(if0.o_rst_div),  32'd0);

        // Request 4 in the second cycle of a high phase.
        repeat (5) tick();
        chk("lit_req4_clk",  32'(if0.o_clk_div),  32'd1);
        if0.i_div_req = 1'b1; if0.i_div_val = 16'd4;
        tick();
        if0.i_div_req = 1'b0;
        chk("lit_req4_busy", 32'(if0.o_div_busy), 32'd1);
        chk("lit_req4_ack",  32'(if0.o_div_ack),  32'd0);
        tick();
        chk("lit_drain_clk", 32'(if0.o_clk_div),  32'd1);
        tick();
        chk("lit_chg_clk",   32'(if0.o_clk_div),  32'd0);
        chk("lit_chg_ack",   32'(if0.o_div_ack),  32'd1);
        chk("lit_chg_busy",  32'(if0.o_div_busy), 32'd0);
        chk("lit_chg_rdiv0", 32'(if0.o_rst_div),  32'd1);
        chk("lit_chg_rdiv1", 32'(if1.o_rst_div),  32'd0);
        tick();
        chk("lit_new_low2",  32'(if0.o_clk_div),  32'd0);
        tick();
        chk("lit_new_rise",  32'(if0.o_ce_rise),  32'd1);
        tick();
        chk("lit_new_rdiv",  32'(if0.o_rst_div),  32'd1);
        tick();
        chk("lit_new_fall",  32'(if0.o_clk_div),  32'd0);
        chk("lit_rdiv_clr",  32'(if0.o_rst_div),  32'd0);

        // Invalid requests: odd and zero.
        if0.i_div_req = 1'b1; if0.i_div_val = 16'd7;
        tick();
        if0.i_div_req = 1'b0;
        chk("lit_err7",      32'(if0.o_div_err),  32'd1);
        chk("lit_err7_busy", 32'(if0.o_div_busy), 32'd0);
        tick();
        chk("lit_err7_end",  32'(if0.o_div_err),  32'd0);
        if0.i_div_req = 1'b1; if0.i_div_val = 16'd0;
        tick();
        if0.i_div_req = 1'b0;
        chk("lit_err0",      32'(if0.o_div_err),  32'd1);
        tick();
        chk("lit_err0_end",  32'(if0.o_div_err),  32'd0);
        measure_high(len);
        chk("lit_h_after_err", 32'(len), 32'd2);

        // Request 6, then 12 while busy: only one ack, final H=3.
        a0 = ack_cnt;
        if0.i_div_req = 1'b1; if0.i_div_val = 16'd6;
        tick();
        chk("lit_req6_busy", 32'(if0.o_div_busy), 32'd1);
        if0.i_div_val = 16'd12;
        tick();
        if0.i_div_req = 1'b0;
        repeat (20) tick();
        chk("lit_one_ack",   32'(ack_cnt - a0),   32'd1);
        measure_high(len);
        chk("lit_h3",        32'(len),            32'd3);

        // Reset while draining discards the pending change.
        if0.i_div_req = 1'b1; if0.i_div_val = 16'd4;
        tick();
        if0.i_div_req = 1'b0;
        chk("lit_drain_busy", 32'(if0.o_div_busy), 32'd1);
        a0 = ack_cnt;
        rst = 1'b1;
        tick();
        chk("lit_hold_clk",  32'(if0.o_clk_div),  32'd0);
        chk("lit_hold_rdiv", 32'(if0.o_rst_div),  32'd1);
        chk("lit_hold_busy", 32'(if0.o_div_busy), 32'd0);
        tick();
        rst = 1'b0;
        repeat (30) tick();
        chk("lit_no_ack",    32'(ack_cnt - a0),   32'd0);
        chk("lit_busy_idle", 32'(if0.o_div_busy), 32'd0);
        measure_high(len);
        chk("lit_h_default", 32'(len),            32'd4);

        // Change 8 -> 16; watch the plain-reset instance for runts.
        track_en = 1'b1;
        tick();
        if0.i_div_req = 1'b1; if0.i_div_val = 16'd16;
        tick();
        if0.i_div_req = 1'b0;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (if0.o_div_ack === 1'b1) begin found = 1; break; end
            tick();
        end
        chk("lit_ack16_seen", 32'(found), 32'd1);
        chk("lit_ack16_rdiv1", 32'(if1.o_rst_div), 32'd0);
        len = 1;
        tick();
        while (if0.o_clk_div === 1'b0 && len < 100) begin
            len++;
            tick();
        end
        chk("lit_low8",      32'(len),            32'd8);
        measure_high(len);
        chk("lit_high8",     32'(len),            32'd8);
        chk("lit_min_high",  32'(min_high >= 4),  32'd1);
        chk("lit_rdiv1_low", 32'(rst1_seen),      32'd0);
        track_en = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
